buzzer_arbiter: RTL and testbench

Input-side control block of the multichannel answering machine. It debounces four player buzzers and three host keys, locks in the first player to buzz, runs the answer window, and keeps per-player scores. Its `player`/`score` outputs feed the tube display driver directly, so the display always shows the active player and that player's score.

---
 rtl/buzzer_arbiter_pkg.sv | 42 ++++
 rtl/buzzer_arbiter_key_debouncer.sv | 51 +++++
 rtl/buzzer_arbiter.sv | 129 ++++++++++++
 tb/tb_buzzer_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_arbiter_pkg.sv
// Shared types and helpers for the buzzer arbiter: FSM encoding, player count
// and the clamped score arithmetic.
package buzzer_arbiter_pkg;

  localparam int unsigned NUM_PLAYERS = 4;
  localparam int unsigned NUM_KEYS    = NUM_PLAYERS + 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ANSWER = 2'd2
  } state_e;

  // Sums are formed 9 bits wide so an overflow past 255 still clamps correctly.
  function automatic logic [7:0] score_add(input logic [7:0] s,
                                           input logic [7:0] pts,
                                           input logic [7:0] max_s);
    logic [8:0] sum;
    sum = {1'b0, s} + {1'b0, pts};
    if (sum > {1'b0, max_s}) return max_s;
    return sum[7:0];
  endfunction

  function automatic logic [7:0] score_sub(input logic [7:0] s,
                                           input logic [7:0] pts);
    logic [8:0] diff;
    diff = {1'b0, s} - {1'b0, pts};
    if (diff[8]) return '0;
    return diff[7:0];
  endfunction

  // Lowest set index wins when several buzzers fire in the same cycle.
  function automatic logic [1:0] first_player(input logic [NUM_PLAYERS-1:0] p);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = NUM_PLAYERS; i > 0; i--) begin
      if (p[i-1]) idx = 2'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/buzzer_arbiter_key_debouncer.sv
// Raw key conditioning: 2-flop synchronizer, stable-level debounce counter and
// a one-cycle pulse on the accepted rising edge.
module key_debouncer #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic [19:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // Counter only runs while the synchronized input disagrees with the level;
    // any return to the old level restarts the qualification.
    if (sync2_q != level_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/buzzer_arbiter.sv
// Quiz buzzer arbiter: debounces buzzers and host keys, locks the first player,
// times the answer window and keeps saturating per-player scores.
module buzzer_arbiter
  import buzzer_arbiter_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [31:0] ANSWER_CYCLES   = 32'd500_000_000,
  parameter logic [7:0]  POINT           = 8'd10,
  parameter logic [7:0]  MAX_SCORE       = 8'd99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] player_btn,
  input  logic       host_start,
  input  logic       host_correct,
  input  logic       host_wrong,
  output logic [1:0] player,
  output logic [7:0] score,
  output logic       locked,
  output logic       armed,
  output logic       foul,
  output logic       timeout
);

  logic [NUM_KEYS-1:0] raw_keys;
  logic [NUM_KEYS-1:0] key_press;

  assign raw_keys = {host_wrong, host_correct, host_start, player_btn};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_i  (raw_keys[g]),
      .press_o(key_press[g])
    );
  end

  logic [NUM_PLAYERS-1:0] pl_press;
  logic                   start_press, correct_press, wrong_press;

  assign pl_press      = key_press[NUM_PLAYERS-1:0];
  assign start_press   = key_press[NUM_PLAYERS];
  assign correct_press = key_press[NUM_PLAYERS+1];
  assign wrong_press   = key_press[NUM_PLAYERS+2];

  state_e                       state_q, state_d;
  logic [1:0]                   player_q, player_d;
  logic [31:0]                  timer_q, timer_d;
  logic                         foul_q, foul_d;
  logic                         timeout_q, timeout_d;
  logic [NUM_PLAYERS-1:0][7:0]  scores_q, scores_d;
  logic [1:0]                   win;

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    timer_d   = timer_q;
    foul_d    = 1'b0;
    timeout_d = 1'b0;
    scores_d  = scores_q;
    win       = first_player(pl_press);

    case (state_q)
      ST_IDLE: begin
        if (|pl_press) begin
          foul_d         = 1'b1;
          player_d       = win;
          scores_d[win]  = score_sub(scores_q[win], POINT);
        end else if (start_press) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (|pl_press) begin
          state_d  = ST_ANSWER;
          player_d = win;
          timer_d  = '0;
        end
      end
      ST_ANSWER: begin
        // A clean judgement outranks expiry; a double judgement is discarded
        // and leaves the window running.
        if (correct_press && !wrong_press) begin
          scores_d[player_q] = score_add(scores_q[player_q], POINT, MAX_SCORE);
          state_d            = ST_IDLE;
        end else if (wrong_press && !correct_press) begin
          scores_d[player_q] = score_sub(scores_q[player_q], POINT);
          state_d            = ST_IDLE;
        end else if (timer_q == ANSWER_CYCLES - 32'd1) begin
          timeout_d          = 1'b1;
          scores_d[player_q] = score_sub(scores_q[player_q], POINT);
          state_d            = ST_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      player_q  <= '0;
      timer_q   <= '0;
      foul_q    <= 1'b0;
      timeout_q <= 1'b0;
      scores_q  <= '0;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      timer_q   <= timer_d;
      foul_q    <= foul_d;
      timeout_q <= timeout_d;
      scores_q  <= scores_d;
    end
  end

  assign player  = player_q;
  assign score   = scores_q[player_q];
  assign locked  = (state_q == ST_ANSWER);
  assign armed   = (state_q == ST_ARMED);
  assign foul    = foul_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Scoreboard bench for buzzer_arbiter with short debounce and answer windows.
module tb_buzzer_arbiter;

  logic       clk;
  logic       rst_n;
  logic [6:0] raw;
  logic [1:0] player;
  logic [7:0] score;
  logic       locked, armed, foul, timeout;

  buzzer_arbiter #(
    .DEBOUNCE_CYCLES(20'd4),
    .ANSWER_CYCLES  (32'd50),
    .POINT          (8'd10),
    .MAX_SCORE      (8'd99)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .player_btn  (raw[3:0]),
    .host_start  (raw[4]),
    .host_correct(raw[5]),
    .host_wrong  (raw[6]),
    .player      (player),
    .score       (score),
    .locked      (locked),
    .armed       (armed),
    .foul        (foul),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] K_START   = 7'h10;
  localparam logic [6:0] K_CORRECT = 7'h20;
  localparam logic [6:0] K_WRONG   = 7'h40;

  typedef struct {
    string      tag;
    logic [1:0] player;
    logic [7:0] score;
    logic       locked;
    logic       armed;
  } exp_t;

  exp_t sb[$];
  int   model[4];
  int   cur_p;
  int   checks;
  int   errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return locked;
      1:       return foul;
      default: return timeout;
    endcase
  endfunction

  // n = cycles until the signal is seen, -1 if the bound expires.
  task automatic wait_sig(input int which, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (sig(which)) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic press(input logic [6:0] m);
    raw = m;
    repeat (10) tick();
    raw = '0;
    repeat (10) tick();
  endtask

  task automatic m_add(input int p);
    model[p] = (model[p] + 10 > 99) ? 99 : model[p] + 10;
  endtask

  task automatic m_sub(input int p);
    model[p] = (model[p] < 10) ? 0 : model[p] - 10;
  endtask

  task automatic push_exp(input string tag, input int p, input int l, input int a);
    exp_t e;
    e.tag    = tag;
    e.player = 2'(p);
    e.score  = 8'(model[p]);
    e.locked = 1'(l);
    e.armed  = 1'(a);
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check_eq({e.tag, "_player"}, 32'(player), 32'(e.player));
    check_eq({e.tag, "_score"},  32'(score),  32'(e.score));
    check_eq({e.tag, "_locked"}, 32'(locked), 32'(e.locked));
    check_eq({e.tag, "_armed"},  32'(armed),  32'(e.armed));
  endtask

  task automatic arm();
    push_exp("arm", cur_p, 0, 1);
    press(K_START);
    pop_check();
  endtask

  task automatic round(input int p, input int judge_wrong);
    arm();
    cur_p = p;
    push_exp("lock", p, 1, 0);
    press(7'(1 << p));
    pop_check();
    if (judge_wrong != 0) m_sub(p);
    else                  m_add(p);
    push_exp("judge", p, 0, 0);
    press(judge_wrong != 0 ? K_WRONG : K_CORRECT);
    pop_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got 0 exp 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int foul_seen;
    checks = 0;
    errors = 0;
    cur_p  = 0;
    for (int i = 0; i < 4; i++) model[i] = 0;
    raw   = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_player",  32'(player),  0);
    check_eq("rst_score",   32'(score),   0);
    check_eq("rst_locked",  32'(locked),  0);
    check_eq("rst_armed",   32'(armed),   0);
    check_eq("rst_foul",    32'(foul),    0);
    check_eq("rst_timeout", 32'(timeout), 0);
    rst_n = 1'b1;
    tick();

    // Start, buzz player 2 with latency measurement, then correct.
    arm();
    cur_p = 2;
    raw   = 7'h04;
    wait_sig(0, 20, n);
    check_eq("lock_latency", n, 7);
    check_eq("lock_player", 32'(player), 2);
    raw = '0;
    repeat (10) tick();
    m_add(2);
    push_exp("p2_correct", 2, 0, 0);
    press(K_CORRECT);
    pop_check();

    // Same-cycle buzz of players 1 and 3, then a late buzz from player 0.
    arm();
    cur_p = 1;
    push_exp("tie_lock", 1, 1, 0);
    press(7'h0A);
    pop_check();
    push_exp("late_ignored", 1, 1, 0);
    press(7'h01);
    pop_check();
    m_add(1);
    push_exp("tie_correct", 1, 0, 0);
    press(K_CORRECT);
    pop_check();

    // Foul by player 0 at score 0.
    cur_p = 0;
    raw   = 7'h01;
    wait_sig(1, 20, n);
    check_eq("foul_latency", n, 7);
    check_eq("foul0_player", 32'(player), 0);
    check_eq("foul0_score",  32'(score),  0);
    check_eq("foul0_armed",  32'(armed),  0);
    tick();
    check_eq("foul_width", 32'(foul), 0);
    raw = '0;
    repeat (10) tick();

    // Foul by player 0 at score 30.
    repeat (3) round(0, 0);
    m_sub(0);
    raw = 7'h01;
    wait_sig(1, 20, n);
    check_eq("foul30_seen", n, 7);
    check_eq("foul30_score", 32'(score), 20);
    raw = '0;
    repeat (10) tick();

    // 95 is unreachable in steps of 10; 90 -> 99 exercises the same clamp.
    repeat (10) round(3, 0);
    check_eq("sat_score", 32'(score), 99);

    // Timeout round for player 3.
    arm();
    raw = 7'h08;
    wait_sig(0, 20, n);
    check_eq("to_lock_latency", n, 7);
    m_sub(3);
    push_exp("timeout_end", 3, 0, 0);
    wait_sig(2, 60, n);
    check_eq("timeout_cycles", n, 50);
    pop_check();
    tick();
    check_eq("timeout_width", 32'(timeout), 0);
    raw = '0;
    repeat (10) tick();

    // Bounce shorter than the debounce window must not register a press.
    foul_seen = 0;
    for (int lvl = 0; lvl < 5; lvl++) begin
      raw = (lvl % 2 == 0) ? 7'h01 : 7'h00;
      repeat (3) begin
        tick();
        if (foul) foul_seen++;
      end
    end
    raw = '0;
    repeat (10) begin
      tick();
      if (foul) foul_seen++;
    end
    check_eq("bounce_foul", foul_seen, 0);
    check_eq("bounce_player", 32'(player), 3);
    check_eq("bounce_score", 32'(score), 32'(model[3]));

    // Correct and wrong together are ignored; a later wrong closes the round.
    arm();
    cur_p = 2;
    push_exp("dual_lock", 2, 1, 0);
    press(7'h04);
    pop_check();
    push_exp("dual_ignored", 2, 1, 0);
    press(K_CORRECT | K_WRONG);
    pop_check();
    m_sub(2);
    push_exp("dual_then_wrong", 2, 0, 0);
    press(K_WRONG);
    pop_check();

    // Reset in the middle of an answer window.
    arm();
    cur_p = 3;
    push_exp("pre_reset_lock", 3, 1, 0);
    press(7'h08);
    pop_check();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_player", 32'(player), 0);
    check_eq("mid_rst_score",  32'(score),  0);
    check_eq("mid_rst_locked", 32'(locked), 0);
    check_eq("mid_rst_armed",  32'(armed),  0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 0;
    cur_p = 0;
    tick();
    check_eq("post_rst_locked", 32'(locked), 0);
    check_eq("post_rst_armed",  32'(armed),  0);
    round(3, 0);
    round(0, 0);
    round(1, 0);

    if (sb.size() != 0) check_eq("scoreboard_leftover", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
